// File: rtl/merge_stage_pkg.sv
// rtl/merge_stage_pkg.sv - shared defaults and state encoding for the merge stage
package merge_stage_pkg;

  localparam int DW_DEFAULT   = 8;
  localparam int HALF_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/half_buffer.sv
// rtl/half_buffer.sv - one sorted half: single write port, asynchronous read port
module half_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Contents deliberately survive reset so a merge can be replayed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/merge_stage.sv
// rtl/merge_stage.sv - streams the stable merge of two sorted 16-element halves
module merge_stage
  import merge_stage_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int HALF = HALF_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [4:0]    out_index
);

  state_t        state, state_nx;
  logic [4:0]    li, ri, idx;
  logic [4:0]    li_nx, ri_nx, idx_nx;
  logic [DW-1:0] l_data, r_data;
  logic          wr_ok, l_empty, r_empty, take_left;

  // Loads are only accepted in IDLE; a load coincident with start lands
  // on the same edge that enters MERGE, so the first read already sees it.
  assign wr_ok = wr_en && (state == IDLE);

  half_buffer #(.DW(DW), .DEPTH(HALF), .AW(4)) u_left (
    .clk     (clk),
    .wr_en   (wr_ok && !wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (li[3:0]),
    .rd_data (l_data)
  );

  half_buffer #(.DW(DW), .DEPTH(HALF), .AW(4)) u_right (
    .clk     (clk),
    .wr_en   (wr_ok && wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (ri[3:0]),
    .rd_data (r_data)
  );

  assign l_empty   = (li == 5'(HALF));
  assign r_empty   = (ri == 5'(HALF));
  // Ties favour left, which keeps the merge stable.
  assign take_left = r_empty || (!l_empty && (l_data <= r_data));

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = (state == MERGE);
  assign out_data  = take_left ? l_data : r_data;
  assign out_index = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      li    <= '0;
      ri    <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      li    <= li_nx;
      ri    <= ri_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    li_nx    = li;
    ri_nx    = ri;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = MERGE;
          li_nx    = '0;
          ri_nx    = '0;
          idx_nx   = '0;
        end
      end
      MERGE: begin
        if (out_ready) begin
          if (take_left) li_nx = l_empty ? li : li + 5'd1;
          else           ri_nx = r_empty ? ri : ri + 5'd1;
          idx_nx = idx + 5'd1;
          if (idx == 5'(2*HALF-1)) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_merge_stage.sv
// tb/tb_merge_stage.sv - randomized and directed checks of merge_stage against a sort-based model
module tb_merge_stage;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, wr_sel, start, out_ready;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, out_data;
  logic       busy, done, out_valid;
  logic [4:0] out_index;

  int checks = 0;
  int errors = 0;

  logic [7:0] lbuf [16];
  logic [7:0] rbuf [16];
  logic [7:0] exp_d [32];
  int         exp_l [33];

  merge_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected stream: stable sort of all 32 elements keyed by value, then source
  // (left before right), then position.
  task automatic build_model();
    int keys[$];
    keys = {};
    for (int i = 0; i < 16; i++) keys.push_back(int'(lbuf[i]) * 64 + i);
    for (int i = 0; i < 16; i++) keys.push_back(int'(rbuf[i]) * 64 + 32 + i);
    keys.sort();
    exp_l[0] = 0;
    for (int k = 0; k < 32; k++) begin
      exp_d[k]   = 8'(keys[k] / 64);
      exp_l[k+1] = exp_l[k] + (((keys[k] % 64) < 32) ? 1 : 0);
    end
  endtask

  task automatic load();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        wr_en   = 1'b1;
        wr_sel  = s[0];
        wr_addr = 4'(i);
        wr_data = (s == 0) ? lbuf[i] : rbuf[i];
        @(posedge clk); #1;
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic rand_halves(input int lo, input int hi);
    int q[$];
    for (int s = 0; s < 2; s++) begin
      q = {};
      for (int i = 0; i < 16; i++) q.push_back(int'($urandom_range(hi, lo)));
      q.sort();
      for (int i = 0; i < 16; i++) begin
        if (s == 0) lbuf[i] = 8'(q[i]);
        else        rbuf[i] = 8'(q[i]);
      end
    end
  endtask

  // mode 0: ready always high, 1: ready 1,0,0,1 repeating, 2: random ready
  task automatic run(input int mode, input bit inject, input int abort_at);
    int n, cyc;
    bit got_done, rdy;
    build_model();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; cyc = 1; got_done = 1'b0;
    chk("busy_rise", busy, 1);
    while (!got_done && cyc < 400) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: rdy = 1'($urandom_range(1, 0));
      endcase
      out_ready = rdy;
      if (inject) begin
        start   = (cyc == 5);
        wr_en   = (cyc == 5);
        wr_sel  = 1'b0;
        wr_addr = 4'd15;
        wr_data = ~lbuf[15];
      end
      if (done) begin
        got_done = 1'b1;
        chk("done_count", n, 32);
        chk("done_valid_low", out_valid, 0);
        if (mode == 0) chk("done_latency", cyc, 33);
      end else if (n > 31) begin
        chk("overrun", n, 31);
        break;
      end else begin
        chk("valid", out_valid, 1);
        chk("busy", busy, 1);
        chk("data", out_data, exp_d[n]);
        chk("index", out_index, n);
        chk("li", dut.li, exp_l[n]);
        chk("ri", dut.ri, n - exp_l[n]);
        if (n == abort_at) begin
          #2 rst_n = 1'b0;
          #1;
          chk("abort_busy", busy, 0);
          chk("abort_valid", out_valid, 0);
          chk("abort_done", done, 0);
          chk("abort_index", out_index, 0);
          @(posedge clk); #1;
          chk("abort_no_done", done, 0);
          rst_n = 1'b1;
          out_ready = 1'b1;
          return;
        end
        if (rdy) n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", got_done, 1);
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_index", out_index, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Interleaved evens/odds
    for (int i = 0; i < 16; i++) begin lbuf[i] = 8'(2*i); rbuf[i] = 8'(2*i + 1); end
    load();
    run(0, 1'b0, -1);

    // All-equal halves: left must drain first
    for (int i = 0; i < 16; i++) begin lbuf[i] = 8'h10; rbuf[i] = 8'h10; end
    load();
    run(0, 1'b0, -1);

    // High left, low right: unsigned compare, right exhausts first
    for (int i = 0; i < 16; i++) begin lbuf[i] = 8'(8'h80 + i); rbuf[i] = 8'(i); end
    load();
    run(0, 1'b0, -1);

    // Interleaved with 1,0,0,1 stalls
    for (int i = 0; i < 16; i++) begin lbuf[i] = 8'(2*i); rbuf[i] = 8'(2*i + 1); end
    load();
    run(1, 1'b0, -1);

    // Abort at index 10, then replay from unchanged buffers
    run(0, 1'b0, 10);
    run(0, 1'b0, -1);

    // start/wr_en while busy are ignored
    run(0, 1'b1, -1);
    run(0, 1'b0, -1);

    // Random halves with duplicates and high values, random backpressure
    for (int t = 0; t < 4; t++) begin
      if (t % 2 == 0) rand_halves(0, 7);
      else            rand_halves(0, 255);
      load();
      run(2, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
